// File: rtl/regfile_bank.sv
// regfile_bank: integer register file for the reduced RISC-V core.
// NUM_READ asynchronous read ports, one synchronous write port, x0 reads as
// zero, optional same-cycle write-to-read bypass. The storage array has no
// reset; a clear sequencer zeroes it one entry per cycle after reset or on
// request, and all read data is forced to zero while that sweep runs.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   clr_start  one-cycle request to re-zero the array (honoured only in IDLE)
//   busy       high while the clear sweep runs
//   ad_rd      packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd         packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   we3        write enable
//   ad3        write address
//   wd3        write data
//   a0         contents of register A0_INDEX (never bypassed)
module regfile_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned A0_INDEX   = 10,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_start,
  output logic                           busy,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ad_rd,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd,
  input  logic                           we3,
  input  logic [ADDR_WIDTH-1:0]          ad3,
  input  logic [DATA_WIDTH-1:0]          wd3,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR  = ADDR_WIDTH'(A0_INDEX);

  // Reject unusable parameterisations at elaboration.
  if (NUM_READ < 1 || A0_INDEX >= DEPTH) begin : g_bad_param
    $error("regfile_bank: NUM_READ must be >= 1 and A0_INDEX < 2**ADDR_WIDTH");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;

  logic                    arr_we;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdata;

  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

  // State register; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state and array write-port selection (sweep owns the port in CLEAR).
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    arr_we    = 1'b0;
    arr_waddr = ad3;
    arr_wdata = wd3;

    unique case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = clr_idx_q;
        arr_wdata = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = ADDR_WIDTH'(clr_idx_q + 1'b1);
        end
      end
      ST_IDLE: begin
        // A user write on the clr_start edge still commits; the sweep erases it.
        arr_we = we3 && (ad3 != '0);
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase

    // Reset edges never touch the array.
    if (!rst_n) begin
      arr_we = 1'b0;
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs_q[arr_waddr] <= arr_wdata;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  // Read lanes: busy and x0 force zero, then bypass, then array contents.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] lane_addr;
    logic [DATA_WIDTH-1:0] lane_data;

    assign lane_addr = ad_rd[gi*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      lane_data = regs_q[lane_addr];
      if (busy || (lane_addr == '0)) begin
        lane_data = '0;
      end else if ((BYPASS != 0) && we3 && (ad3 == lane_addr)) begin
        lane_data = wd3;
      end
    end

    assign rd[gi*DATA_WIDTH +: DATA_WIDTH] = lane_data;
  end

  // Debug tap on the ABI return register; shows committed contents only.
  assign a0 = busy ? '0 : regs_q[A0_ADDR];

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: a 4-port bypassing instance and a 2-port
// non-bypassing instance share one stimulus stream and one reference model.
module tb_regfile_bank;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic            clk;
  logic            rst_n;
  logic            clr_start;
  logic            we3;
  logic [AW-1:0]   ad3;
  logic [DW-1:0]   wd3;
  logic [4*AW-1:0] ad_rd;

  logic            busy, busy_nb;
  logic [4*DW-1:0] rd;
  logic [2*DW-1:0] rd_nb;
  logic [DW-1:0]   a0, a0_nb;

  regfile_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(4), .A0_INDEX(10), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy),
    .ad_rd(ad_rd), .rd(rd), .we3(we3), .ad3(ad3), .wd3(wd3), .a0(a0)
  );

  regfile_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .A0_INDEX(10), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy_nb),
    .ad_rd(ad_rd[2*AW-1:0]), .rd(rd_nb), .we3(we3), .ad3(ad3), .wd3(wd3), .a0(a0_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents plus remaining sweep cycles.
  logic [DW-1:0] mdl [DEPTH];
  bit            busy_m;
  int            left_m;
  bit            chk_en;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (busy_m || a == 0) return '0;
    if (byp && we3 && ad3 == a) return wd3;
    return mdl[a];
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] a;
    check("busy", 128'(busy), 128'(busy_m));
    check("busy_nb", 128'(busy_nb), 128'(busy_m));
    check("a0", 128'(a0), 128'(busy_m ? '0 : mdl[10]));
    check("a0_nb", 128'(a0_nb), 128'(busy_m ? '0 : mdl[10]));
    for (int i = 0; i < 4; i++) begin
      a = ad_rd[i*AW +: AW];
      check($sformatf("rd%0d", i), 128'(rd[i*DW +: DW]), 128'(exp_rd(a, 1'b1)));
    end
    for (int i = 0; i < 2; i++) begin
      a = ad_rd[i*AW +: AW];
      check($sformatf("rd_nb%0d", i), 128'(rd_nb[i*DW +: DW]), 128'(exp_rd(a, 1'b0)));
    end
  endtask

  // Apply one rising edge to the model; after a sweep the array is all zero,
  // so the model zeroes it at sweep entry (contents are hidden meanwhile).
  task automatic model_edge();
    if (!rst_n) begin
      busy_m = 1'b1;
      left_m = DEPTH;
      foreach (mdl[k]) mdl[k] = '0;
    end else if (busy_m) begin
      left_m--;
      if (left_m == 0) busy_m = 1'b0;
    end else begin
      if (we3 && ad3 != 0) mdl[ad3] = wd3;
      if (clr_start) begin
        busy_m = 1'b1;
        left_m = DEPTH;
        foreach (mdl[k]) mdl[k] = '0;
      end
    end
  endtask

  task automatic cycle();
    #1;
    if (chk_en) check_outputs();
    @(posedge clk);
    model_edge();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic set_all_rd(input logic [AW-1:0] a);
    ad_rd = {a, a, a, a};
  endtask

  initial begin
    chk_en    = 1'b0;
    busy_m    = 1'b0;
    left_m    = 0;
    rst_n     = 1'b0;
    clr_start = 1'b0;
    we3       = 1'b0;
    ad3       = '0;
    wd3       = '0;
    ad_rd     = '0;
    foreach (mdl[k]) mdl[k] = '0;

    // Reset sweep: 3 reset cycles, then exactly 32 busy cycles.
    repeat (3) cycle();
    rst_n = 1'b1;
    set_all_rd(5'd10);
    repeat (32) cycle();
    #1;
    check("busy_after_sweep", 128'(busy), 128'(0));
    for (int a = 1; a < 32; a++) begin
      set_all_rd(AW'(a));
      cycle();
    end

    // Basic write/read and a0 tap.
    we3 = 1'b1; ad3 = 5'd5; wd3 = 32'hDEADBEEF;
    cycle();
    we3 = 1'b0; ad_rd = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    check("x5_read", 128'(rd[31:0]), 128'(32'hDEADBEEF));
    cycle();
    we3 = 1'b1; ad3 = 5'd10; wd3 = 32'h0000002A;
    cycle();
    we3 = 1'b0;
    #1;
    check("a0_2a", 128'(a0), 128'(32'h2A));
    cycle();

    // x0 discard and bypass vs. non-bypass.
    we3 = 1'b1; ad3 = 5'd0; wd3 = 32'hFFFFFFFF; set_all_rd(5'd0);
    cycle();
    we3 = 1'b0;
    cycle();
    we3 = 1'b1; ad3 = 5'd7; wd3 = 32'h99;
    cycle();
    wd3 = 32'h1234; ad_rd = {5'd0, 5'd0, 5'd7, 5'd0};
    #1;
    check("bypass_rd1", 128'(rd[63:32]), 128'(32'h1234));
    check("nobypass_rd1", 128'(rd_nb[63:32]), 128'(32'h99));
    cycle();
    we3 = 1'b0;
    cycle();

    // Writes during busy are dropped; the clr_start-edge write is erased too.
    we3 = 1'b1; ad3 = 5'd3; wd3 = 32'h77; clr_start = 1'b1;
    cycle();
    clr_start = 1'b0; wd3 = 32'h55;
    repeat (32) cycle();
    we3 = 1'b0; ad_rd = {5'd0, 5'd0, 5'd0, 5'd3};
    #1;
    check("x3_cleared", 128'(rd[31:0]), 128'(0));
    check("busy_idle", 128'(busy), 128'(0));
    cycle();

    // Reset mid-sweep restarts the full sweep.
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (9) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (32) cycle();
    #1;
    check("busy_after_restart", 128'(busy), 128'(0));

    // Multi-port read of the same and different indices.
    we3 = 1'b1; ad3 = 5'd1; wd3 = 32'hA;
    cycle();
    ad3 = 5'd2; wd3 = 32'hB;
    cycle();
    we3 = 1'b0; ad_rd = {5'd0, 5'd2, 5'd1, 5'd1};
    #1;
    check("multiport", 128'(rd), {32'h0, 32'hB, 32'hA, 32'hA});
    cycle();

    // Randomised traffic against the model.
    repeat (400) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      clr_start = ($urandom_range(0, 39) == 0);
      we3       = ($urandom_range(0, 1) == 1);
      ad3       = AW'($urandom_range(0, 31));
      wd3       = $urandom;
      ad_rd     = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                   AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) ad_rd[AW-1:0] = ad3;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
Parametrised integer register file for the reduced RISC-V core: NUM_READ asynchronous read ports, one synchronous write port, x0 hardwired to zero, and write-to-read bypass. The block holds no reset on the storage array. A built-in clear sequencer zeroes the array one entry per cycle after reset or on request, and raises busy while it runs. A debug tap exposes the ABI return register (a0) to the top level and testbench.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (>=1)
A0_INDEX, 10, register index mirrored on a0 (x10 per RISC-V ABI)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read old contents

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
clr_start  input  1  one-cycle request to re-zero the array; honoured only in IDLE
busy  output  1  high while the clear sweep runs
ad_rd  input  NUM_READ*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd  output  NUM_READ*DATA_WIDTH  read data, same packing as ad_rd
we3  input  1  write enable
ad3  input  ADDR_WIDTH  write address
wd3  input  DATA_WIDTH  write data
a0  output  DATA_WIDTH  contents of register A0_INDEX

Behaviour:
- Reset and clocking: one clock, clk. Reset rst_n is synchronous and active-low. It is sampled only on the rising edge of clk.
- FSM states: CLEAR and IDLE. Two state registers: state and clr_idx (ADDR_WIDTH bits).
- rst_n low at an edge:
  - state <= CLEAR, clr_idx <= 0.
  - No array write occurs on that edge.
  - busy = 1 from the next cycle and stays 1 while rst_n is held low.
- CLEAR with rst_n high:
  - Each edge writes 0 to entry clr_idx and increments clr_idx.
  - On the edge that writes entry DEPTH-1: state <= IDLE, clr_idx <= 0.
  - busy therefore stays high for exactly DEPTH cycles after rst_n is released.
- IDLE:
  - clr_start = 1 at an edge: state <= CLEAR, clr_idx <= 0.
  - That edge still performs a pending user write. That write is subsequently overwritten by the sweep.
  - clr_start is ignored while in CLEAR; the sweep does not restart.
- busy = (state == CLEAR). Reset value is 1.
- While busy:
  - we3 is ignored; no user write commits.
  - All rd lanes and a0 drive 0.
- User write (IDLE only):
  - If we3 = 1 and ad3 != 0, registers[ad3] <= wd3 on the rising edge.
  - Writes to index 0 are discarded.
- Read port i is combinational, with this priority:
  - busy → 0
  - else ad_rd[i] == 0 → 0
  - else BYPASS = 1, we3 = 1 and ad3 == ad_rd[i] → wd3
  - else registers[ad_rd[i]]
- Read ports:
  - All ports are independent.
  - Any number of ports may read the same index.
  - Reads never stall.
- a0:
  - Combinational: 0 while busy, else registers[A0_INDEX].
  - Never bypassed; a write to A0_INDEX is visible on a0 the cycle after the edge.
- Latency: write-to-read is 0 cycles with BYPASS = 1 and 1 cycle with BYPASS = 0.
- Widths: no arithmetic on data. clr_idx wraps at DEPTH but is reset to 0 on every entry to CLEAR.
- Array contents before the first completed sweep are undefined. The busy gating guarantees none is ever observable on rd or a0.
- Reset mid-sweep: the sweep restarts from index 0 with full DEPTH-cycle duration.
- Parameter check: elaboration fails if NUM_READ < 1 or A0_INDEX >= DEPTH.

Test Plan:
- Reset sweep: hold rst_n = 0 for 3 cycles, then release. Required: busy = 1 for exactly 32 cycles after release, rd = 0 and a0 = 0 throughout, busy = 0 on cycle 33. Afterwards, reading every index 1..31 returns 0.
- Basic write/read: write x5 = 0xDEADBEEF with we3 = 1. Next cycle with we3 = 0, ad_rd port0 = 5 → rd0 = 0xDEADBEEF. Write x10 = 0x0000002A → a0 = 0x2A on the following cycle.
- x0 and bypass: write x0 = 0xFFFFFFFF → any port reading 0 returns 0, now and in later cycles. Same cycle we3 = 1, ad3 = 7, wd3 = 0x1234 with port1 reading 7 → rd1 = 0x1234 combinationally (BYPASS = 1). Repeat with BYPASS = 0 → rd1 shows the old x7 value.
- Writes during busy: assert clr_start in IDLE. Over the next 32 cycles drive we3 = 1, ad3 = 3, wd3 = 0x55. Required: busy = 1 for 32 cycles, then x3 = 0. A write of x3 = 0x77 on the clr_start edge is also zero after the sweep.
- Reset mid-sweep: pulse clr_start, then drive rst_n = 0 for 1 cycle at sweep cycle 10. Required: busy stays high for 32 further cycles after release, and all entries end at 0.
- Multi-port (NUM_READ = 4): four ports read x1, x1, x2 and x0 after x1 = 0xA and x2 = 0xB. Required: rd = {0x0, 0xB, 0xA, 0xA} (port3 down to port0).
